// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types used by the cache/memory plumbing.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  // Which requester last completed a transaction on the shared memory port.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } lc3b_arb_grant;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port between the instruction
// and data sides.  One idle cycle separates every grant; a stalled memory
// is cut off after TIMEOUT_CYCLES wait cycles and flagged on mem_err.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          i_read,
  input  logic          i_write,
  input  lc3b_word      i_address,
  input  lc3b_word      i_wdata,
  input  lc3b_mem_wmask i_byte_enable,
  output lc3b_word      i_rdata,
  output logic          i_resp,

  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_byte_enable,
  output lc3b_word      d_rdata,
  output logic          d_resp,

  output logic          mem_read,
  output logic          mem_write,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  output lc3b_mem_wmask mem_byte_enable,
  input  logic          mem_resp,
  input  lc3b_word      mem_rdata,

  output logic          mem_err
);

  // Counter must hold TIMEOUT_CYCLES itself; never narrower than a byte.
  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  arb_state_e       state;
  lc3b_arb_grant    last_grant;
  logic [CNT_W-1:0] wait_cnt;

  logic          i_pending;
  logic          d_pending;
  logic          serving;
  logic          serve_d;
  logic          sel_read;
  logic          sel_write;
  logic          sel_pending;
  logic          timeout;
  logic          resp_any;
  lc3b_word      resp_data;

  assign i_pending = i_read | i_write;
  assign d_pending = d_read | d_write;
  assign serving   = (state != IDLE);
  assign serve_d   = (state == SERVE_D);

  // Granted requester's strobes; in IDLE they are masked by 'serving'.
  assign sel_read    = serve_d ? d_read  : i_read;
  assign sel_write   = serve_d ? d_write : i_write;
  assign sel_pending = sel_read | sel_write;

  // A real response in the same cycle always beats the timeout.
  assign timeout   = serving & sel_pending & ~mem_resp & (wait_cnt == TIMEOUT_VAL);
  assign resp_any  = serving & sel_pending & (mem_resp | timeout);
  assign resp_data = timeout ? 16'h0000 : mem_rdata;

  // Shared memory port follows the granted requester; write wins over read.
  assign mem_address     = serve_d ? d_address     : i_address;
  assign mem_wdata       = serve_d ? d_wdata       : i_wdata;
  assign mem_byte_enable = serve_d ? d_byte_enable : i_byte_enable;
  assign mem_read        = serving & sel_read & ~sel_write & ~timeout;
  assign mem_write       = serving & sel_write & ~timeout;

  // Responses only ever reach the granted side.
  assign i_resp  = resp_any & (state == SERVE_I);
  assign d_resp  = resp_any & serve_d;
  assign i_rdata = (state == SERVE_I) ? resp_data : mem_rdata;
  assign d_rdata = serve_d            ? resp_data : mem_rdata;

  // Arbitration FSM, round-robin history, wait counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      wait_cnt   <= '0;
      mem_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (i_pending && (!d_pending || last_grant == GRANT_D)) begin
            state <= SERVE_I;
          end else if (d_pending) begin
            state <= SERVE_D;
          end
        end
        SERVE_I, SERVE_D: begin
          if (!sel_pending) begin
            state <= IDLE;
          end else if (mem_resp || timeout) begin
            state      <= IDLE;
            last_grant <= serve_d ? GRANT_D : GRANT_I;
            if (timeout) begin
              mem_err <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  import lc3b_types::*;

  localparam int T     = 4;
  localparam int BOUND = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read, i_write, d_read, d_write;
  lc3b_word      i_address, i_wdata, d_address, d_wdata;
  lc3b_mem_wmask i_byte_enable, d_byte_enable, mem_byte_enable;
  lc3b_word      i_rdata, d_rdata, mem_address, mem_wdata, mem_rdata;
  logic          i_resp, d_resp, mem_read, mem_write, mem_resp, mem_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_byte_enable(i_byte_enable), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // owner: 0 = nobody, 1 = I, 2 = D.  last: who finished last (1/2).
  int owner  = 0;
  int waited = 0;
  int last   = 2;
  bit err    = 0;
  bit exp_i_resp = 0;
  bit exp_d_resp = 0;

  // Advance the model by one clock using the inputs seen at that edge.
  always @(posedge clk) begin
    bit pi, pd, pend;
    pi = i_read | i_write;
    pd = d_read | d_write;
    if (reset) begin
      owner = 0; waited = 0; last = 2; err = 0;
    end else if (owner == 0) begin
      waited = 0;
      if (pi && pd)  owner = (last == 1) ? 2 : 1;
      else if (pi)   owner = 1;
      else if (pd)   owner = 2;
    end else begin
      pend = (owner == 1) ? pi : pd;
      if (!pend)              owner = 0;
      else if (mem_resp)      begin last = owner; owner = 0; end
      else if (waited == T)   begin err = 1; last = owner; owner = 0; end
      else                    waited++;
    end
  end

  // Compare every DUT output that matters against the model, mid-cycle.
  always @(negedge clk) begin
    bit r, w, pend, er, ew, eresp;
    lc3b_word erd;
    er = 0; ew = 0; eresp = 0; erd = mem_rdata;
    if (owner != 0) begin
      r = (owner == 1) ? i_read  : d_read;
      w = (owner == 1) ? i_write : d_write;
      pend = r | w;
      if (pend) begin
        if (mem_resp)          begin er = r & ~w; ew = w; eresp = 1; end
        else if (waited == T)  begin eresp = 1; erd = 16'h0000; end
        else                   begin er = r & ~w; ew = w; end
        chk("mem_address", mem_address, (owner == 1) ? i_address : d_address);
        chk("mem_wdata", mem_wdata, (owner == 1) ? i_wdata : d_wdata);
        chk("mem_byte_enable", mem_byte_enable, (owner == 1) ? i_byte_enable : d_byte_enable);
      end
    end
    exp_i_resp = eresp && (owner == 1);
    exp_d_resp = eresp && (owner == 2);
    chk("mem_read", mem_read, er);
    chk("mem_write", mem_write, ew);
    chk("i_resp", i_resp, exp_i_resp);
    chk("d_resp", d_resp, exp_d_resp);
    chk("mem_err", mem_err, err);
    if (exp_i_resp) chk("i_rdata", i_rdata, erd);
    if (exp_d_resp) chk("d_rdata", d_rdata, erd);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
  endtask

  int i_busy, d_busy, i_age, d_age;

  initial begin
    reset = 1; clear_reqs(); mem_resp = 0; mem_rdata = 16'h0;
    i_address = 0; i_wdata = 0; i_byte_enable = 2'b11;
    d_address = 0; d_wdata = 0; d_byte_enable = 2'b11;

    // I-only read, memory answers on the third serve cycle.
    step(); step(); mid();
    chk("lit_reset_err", mem_err, 0);
    chk("lit_reset_read", mem_read, 0);
    step(); reset = 0; i_read = 1; i_address = 16'h0010; mid();
    chk("lit_c1_read", mem_read, 0);
    step(); mid();
    chk("lit_c2_read", mem_read, 1);
    chk("lit_c2_addr", mem_address, 16'h0010);
    step(); mid();
    chk("lit_c3_read", mem_read, 1);
    chk("lit_c3_iresp", i_resp, 0);
    step(); mem_resp = 1; mem_rdata = 16'hBEEF; mid();
    chk("lit_c4_iresp", i_resp, 1);
    chk("lit_c4_irdata", i_rdata, 16'hBEEF);
    chk("lit_c4_dresp", d_resp, 0);
    chk("lit_c4_read", mem_read, 1);
    step(); mem_resp = 0; i_read = 0; mid();
    chk("lit_c5_iresp", i_resp, 0);
    chk("lit_c5_read", mem_read, 0);

    // Tie straight out of reset: I first, then D.
    reset = 1; step(); step();
    reset = 0; i_read = 1; i_address = 16'h0020; d_read = 1; d_address = 16'h0030; mid();
    chk("lit_tie_idle", mem_read, 0);
    step(); mid();
    chk("lit_tie_i_addr", mem_address, 16'h0020);
    step(); mem_resp = 1; mid();
    chk("lit_tie_iresp", i_resp, 1);
    step(); mem_resp = 0; i_read = 0; mid();
    chk("lit_tie_gap", mem_read, 0);
    step(); mid();
    chk("lit_tie_d_addr", mem_address, 16'h0030);
    chk("lit_tie_d_read", mem_read, 1);
    step(); mem_resp = 1; mid();
    chk("lit_tie_dresp", d_resp, 1);
    step(); mem_resp = 0; d_read = 0;

    // D byte write.
    d_write = 1; d_address = 16'h0100; d_wdata = 16'h1234; d_byte_enable = 2'b01; mid();
    step(); mem_resp = 1; mid();
    chk("lit_wr_write", mem_write, 1);
    chk("lit_wr_read", mem_read, 0);
    chk("lit_wr_addr", mem_address, 16'h0100);
    chk("lit_wr_data", mem_wdata, 16'h1234);
    chk("lit_wr_be", mem_byte_enable, 2'b01);
    chk("lit_wr_dresp", d_resp, 1);
    step(); mem_resp = 0; d_write = 0; d_byte_enable = 2'b11;

    // Requester withdraws mid-transaction.
    d_read = 1; d_address = 16'h0200;
    step(); mid();
    chk("lit_abort_read", mem_read, 1);
    step(); d_read = 0; mid();
    chk("lit_abort_dresp", d_resp, 0);
    chk("lit_abort_noread", mem_read, 0);
    step();

    // Memory never answers: timeout after T wait cycles.
    i_read = 1; i_address = 16'h0040; mem_rdata = 16'hFFFF; mid();
    for (int k = 0; k < T; k++) begin
      step(); mid();
      chk("lit_to_wait_read", mem_read, 1);
      chk("lit_to_wait_iresp", i_resp, 0);
    end
    step(); mid();
    chk("lit_to_iresp", i_resp, 1);
    chk("lit_to_rdata", i_rdata, 16'h0000);
    chk("lit_to_read", mem_read, 0);
    chk("lit_to_err_before", mem_err, 0);
    step(); i_read = 0; d_read = 1; d_address = 16'h0050; mid();
    chk("lit_to_err_after", mem_err, 1);
    step(); mem_resp = 1; mem_rdata = 16'hABCD; mid();
    chk("lit_after_to_dresp", d_resp, 1);
    chk("lit_after_to_rdata", d_rdata, 16'hABCD);
    chk("lit_after_to_err", mem_err, 1);
    step(); mem_resp = 0; d_read = 0;

    // Reset in the middle of a D transaction.
    d_read = 1; d_address = 16'h0060; mid();
    step(); mid();
    chk("lit_rst_serving", mem_read, 1);
    step(); reset = 1; i_read = 1; i_address = 16'h0070; mid();
    chk("lit_rst_dresp0", d_resp, 0);
    step(); mid();
    chk("lit_rst_read", mem_read, 0);
    chk("lit_rst_dresp", d_resp, 0);
    chk("lit_rst_err", mem_err, 0);
    step(); reset = 0; mid();
    chk("lit_rst_idle", mem_read, 0);
    step(); mid();
    chk("lit_rst_tie_i", mem_address, 16'h0070);
    step(); mem_resp = 1; mid();
    chk("lit_rst_iresp", i_resp, 1);
    step(); mem_resp = 0; i_read = 0; mid();
    step(); mem_resp = 1; mid();
    chk("lit_rst_dresp_later", d_resp, 1);
    step(); mem_resp = 0; d_read = 0; step();

    // Randomized traffic; second half keeps D requesting continuously.
    i_busy = 0; d_busy = 0; i_age = 0; d_age = 0;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (i_busy != 0) begin
        i_age++;
        if (exp_i_resp) begin
          chk("starve_i", (i_age <= BOUND), 1);
          i_busy = 0; i_read = 0; i_write = 0;
        end
      end
      if (d_busy != 0) begin
        d_age++;
        if (exp_d_resp) begin
          chk("starve_d", (d_age <= BOUND), 1);
          d_busy = 0; d_read = 0; d_write = 0;
        end
      end
      if (i_busy == 0 && $urandom_range(0, 3) == 0) begin
        i_busy = 1; i_age = 0;
        i_read = 1'($urandom); i_write = 1'($urandom);
        if (!i_read && !i_write) i_read = 1;
        i_address = 16'($urandom); i_wdata = 16'($urandom); i_byte_enable = 2'($urandom);
      end
      if (d_busy == 0 && (n >= 2000 || $urandom_range(0, 2) == 0)) begin
        d_busy = 1; d_age = 0;
        d_read = 1'($urandom); d_write = 1'($urandom);
        if (!d_read && !d_write) d_write = 1;
        d_address = 16'($urandom); d_wdata = 16'($urandom); d_byte_enable = 2'($urandom);
      end
      mem_resp  = ($urandom_range(0, 9) < 3);
      mem_rdata = 16'($urandom);
    end
    step();
    chk("starve_i_end", (i_age <= BOUND + 1 || i_busy == 0), 1);
    chk("starve_d_end", (d_age <= BOUND + 1 || d_busy == 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
